// File: rtl/if_pc_gen_pkg.sv
// Shared widths, stall encodings, reset vector and PC-generator state encodings
// for the fetch stage.
package if_pc_gen_pkg;
  localparam int          STALL_WD    = 6;
  localparam int          BR_WD       = 33;
  localparam int          IF_TO_ID_WD = 33;
  localparam logic [31:0] RESET_VEC   = 32'hBFC0_0000;
  localparam logic        Stop        = 1'b1;
  localparam logic        NoStop      = 1'b0;

  typedef logic [STALL_WD-1:0] StallBus;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;
endpackage

// File: rtl/if_br_buffer.sv
// One-entry redirect holding register: remembers a branch raised while the
// PC is stalled until the PC is next allowed to move.
module if_br_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [31:0] capture_addr,
  input  logic        consume,
  output logic        br_pend,
  output logic [31:0] br_pend_addr
);
  // capture and consume are mutually exclusive (stalled vs. advancing), and a
  // repeated capture simply overwrites the address: last writer wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_pend      <= 1'b0;
      br_pend_addr <= 32'd0;
    end else if (capture) begin
      br_pend      <= 1'b1;
      br_pend_addr <= capture_addr;
    end else if (consume) begin
      br_pend      <= 1'b0;
    end
  end
endmodule

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator: picks the next PC, drives the instruction SRAM
// read port and the IF->ID bus, and buffers redirects raised under stall.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VEC,
  parameter int          STALL_W    = STALL_WD,
  parameter int          BR_W       = BR_WD,
  parameter int          IF_TO_ID_W = IF_TO_ID_WD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic [BR_W-1:0]       br_bus,
  output logic [IF_TO_ID_W-1:0] if_to_id_bus,
  output logic                  inst_sram_en,
  output logic [3:0]            inst_sram_wen,
  output logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  output logic                  fetch_adel,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
);
  localparam logic [31:0] PC_RST = RESET_PC - 32'd4;

  pc_state_e   state, state_nxt;
  logic [31:0] pc_r, next_pc, br_addr, br_pend_addr;
  logic        ce_r, br_e, br_pend, stop;
  logic        boot_ld, pc_upd, br_capture;
  logic        unused_ok;

  assign br_e      = br_bus[BR_W-1];
  assign br_addr   = br_bus[31:0];
  assign stop      = (stall[0] == Stop);
  assign unused_ok = ^stall[STALL_W-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = stop ? HOLD : RUN;
      HOLD:    state_nxt = stop ? HOLD : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Branch inputs are ignored in BOOT; the first fetch is always RESET_PC.
  always_comb begin
    boot_ld    = 1'b0;
    pc_upd     = 1'b0;
    br_capture = 1'b0;
    case (state)
      BOOT:      boot_ld = 1'b1;
      RUN, HOLD: begin
        pc_upd     = !stop;
        br_capture = stop && br_e;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (br_e)         next_pc = br_addr;
    else if (br_pend) next_pc = br_pend_addr;
    else              next_pc = pc_r + 32'd4;
  end

  if_br_buffer u_br_buffer (
    .clk          (clk),
    .rst          (rst),
    .capture      (br_capture),
    .capture_addr (br_addr),
    .consume      (pc_upd),
    .br_pend      (br_pend),
    .br_pend_addr (br_pend_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= PC_RST;
      ce_r <= 1'b0;
    end else if (boot_ld) begin
      pc_r <= RESET_PC;
      ce_r <= 1'b1;
    end else if (pc_upd) begin
      pc_r <= next_pc;
    end
  end

  // Misaligned PCs are flagged but not fetched; decode raises the exception.
  assign fetch_adel      = ce_r & (pc_r[1:0] != 2'b00);
  assign inst_sram_en    = ce_r & ~fetch_adel;
  assign inst_sram_addr  = pc_r;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'd0;
  assign if_to_id_bus    = {ce_r, pc_r};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (inst_sram_en && !stop) fetch_cnt <= fetch_cnt + 32'd1;
      if (ce_r && stop)          stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_if_pc_gen.sv
// Directed bench for if_pc_gen: the driver queues each expected PC, and a
// negedge monitor pops and checks whenever the bus shows ce = 1.
module tb_if_pc_gen;
  logic        clk, rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en, fetch_adel;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, fetch_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  if_pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_adel      (fetch_adel),
    .fetch_cnt       (fetch_cnt),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One cycle of stimulus; epc is the PC the bus must show during this cycle.
  task automatic step(input logic s, input logic be, input logic [31:0] ba,
                      input logic vld, input logic [31:0] epc);
    stall  = {5'b0, s};
    br_bus = {be, ba};
    if (vld) exp_q.push_back(epc);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && if_to_id_bus[32]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch got=%h exp=none", if_to_id_bus[31:0]);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pc",   if_to_id_bus[31:0], e);
        chk("addr", inst_sram_addr, e);
        chk("adel", {31'd0, fetch_adel}, {31'd0, e[1:0] != 2'b00});
        chk("en",   {31'd0, inst_sram_en}, {31'd0, e[1:0] == 2'b00});
      end
    end
  end

  initial begin
    rst    = 1'b0;
    stall  = 6'd0;
    br_bus = 33'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus",   if_to_id_bus[31:0], 32'hBFBF_FFFC);
    chk("rst_ce",    {31'd0, if_to_id_bus[32]}, 32'd0);
    chk("rst_en",    {31'd0, inst_sram_en}, 32'd0);
    chk("rst_adel",  {31'd0, fetch_adel}, 32'd0);
    chk("rst_fcnt",  fetch_cnt, 32'd0);
    chk("rst_scnt",  stall_cnt, 32'd0);
    chk("rst_wen",   {28'd0, inst_sram_wen}, 32'd0);
    chk("rst_wdata", inst_sram_wdata, 32'd0);
    rst = 1'b1;
    // BOOT cycle: bus still shows the reset PC with ce = 0; br_e is ignored
    #1;
    chk("boot_ce", {31'd0, if_to_id_bus[32]}, 32'd0);
    chk("boot_pc", if_to_id_bus[31:0], 32'hBFBF_FFFC);
    step(1'b0, 1'b1, 32'hBFC0_0900, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0004);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0008);
    chk("fcnt_3", fetch_cnt, 32'd3);
    // live branch, no stall
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_000C);
    step(1'b0, 1'b1, 32'hBFC0_0100, 1'b1, 32'hBFC0_0010);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0100);
    step(1'b0, 1'b1, 32'hBFC0_0020, 1'b1, 32'hBFC0_0104);
    // 3 stalled cycles, branch on the 2nd one
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hBFC0_0020);
    step(1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 32'hBFC0_0020);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hBFC0_0020);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0020);
    chk("scnt_3", stall_cnt, 32'd3);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0200);
    // pending branch overridden by live branch on release
    step(1'b1, 1'b1, 32'hBFC0_0300, 1'b1, 32'hBFC0_0204);
    step(1'b0, 1'b1, 32'hBFC0_0400, 1'b1, 32'hBFC0_0204);
    chk("scnt_4", stall_cnt, 32'd4);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0400);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0404);
    // misaligned target
    step(1'b0, 1'b1, 32'hBFC0_0102, 1'b1, 32'hBFC0_0408);
    chk("fcnt_13", fetch_cnt, 32'd13);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0102);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0106);
    chk("fcnt_adel", fetch_cnt, 32'd13);
    step(1'b0, 1'b1, 32'hBFC0_0500, 1'b1, 32'hBFC0_010A);
    // async reset mid-HOLD with a pending branch
    step(1'b1, 1'b1, 32'hBFC0_0600, 1'b1, 32'hBFC0_0500);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hBFC0_0500);
    #1 rst = 1'b0;
    #1;
    chk("arst_bus",  if_to_id_bus[31:0], 32'hBFBF_FFFC);
    chk("arst_ce",   {31'd0, if_to_id_bus[32]}, 32'd0);
    chk("arst_en",   {31'd0, inst_sram_en}, 32'd0);
    chk("arst_fcnt", fetch_cnt, 32'd0);
    chk("arst_scnt", stall_cnt, 32'd0);
    stall  = 6'd0;
    br_bus = 33'd0;
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0004);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0008);
    chk("fcnt_restart", fetch_cnt, 32'd3);
    #1 rst = 1'b0;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
